sensor_packet_checker: RTL
==========================

// Module: sensor_packet_checker
// PURPOSE
//  Downstream of the sensor acquisition AXIS packetiser, ahead of the DMA. Frames each packet:
//  header 0xAAAAAAAA, timestamp, N payload words, footer 0x55555555. Validates and store-and-forwards
//  good packets through a commit/rewind FIFO. Drops bad packets whole and counts errors.
//  The source ignores tready, so the input must accept one word every cycle.
// PARAMETERS
//  FIFO_DEPTH  1024  words of packet buffer; power of two, >=1024
//  AW          10    log2(FIFO_DEPTH); pointers are AW+1 bits (MSB = wrap bit)
// PORTS
//  master_clock    in   1   sole clock (40 MHz)
//  reset           in   1   one clock; reset is synchronous and active-high
//  raw_mode        in   1   1: N=512 (raw); 0: N=3 (processed). Sampled when a header is accepted
//  in_tdata        in   32  upstream packet word
//  in_tvalid       in   1   word strobe
//  in_tlast        in   1   marks final footer of a batch
//  in_tready       out  1   constant 1 (source does not honour backpressure)
//  out_tdata       out  32  committed packet word
//  out_tvalid      out  1   AXIS valid
//  out_tlast       out  1   on footer word whose input footer carried tlast
//  out_tready      in   1   AXIS ready from DMA
//  pkt_good_count  out  16  committed packets, wraps
//  err_sync        out  8   words discarded outside a packet, saturating
//  err_footer      out  8   footer mismatches, saturating
//  err_overflow    out  8   packets dropped for lack of space, saturating
//  dbg_state       out  4   parser state
// BEHAVIOUR
//  Reset: all pointers 0; state IDLE; out_tvalid/out_tlast 0; all counters 0; dbg_state 0.
//  Reset has priority over every event; a packet in progress is lost.
//  Parser FSM, advances only on in_tvalid:
//   IDLE(0)    HEADER_VALUE -> write word, pkt_start<=wr_ptr, latch N, clear ovf, go TSTAMP;
//              any other word -> err_sync++, stay.
//   TSTAMP(1)  write word unconditionally; cnt<=0; go PAYLOAD.
//   PAYLOAD(2) write word; cnt++; when cnt==N-1 go FOOTER.
//              Payload is never pattern-matched. Framing is by length only.
//   FOOTER(3)  FOOTER_VALUE and !ovf -> write word with tlast bit, commit_ptr<=wr_ptr+1,
//                pkt_good_count++, go IDLE.
//              FOOTER_VALUE and ovf -> wr_ptr<=pkt_start, err_overflow++, go IDLE.
//              Mismatch -> wr_ptr<=pkt_start, err_footer++. If the word is HEADER_VALUE,
//                restart in the same cycle: write it at pkt_start, go TSTAMP. Otherwise go IDLE.
//  Overflow: a write is required while wr_ptr-rd_ptr==FIFO_DEPTH -> set ovf, suppress the write,
//   keep parsing to the footer position, then rewind. Committed data is never overwritten.
//  FIFO storage: 33 bits per entry ({tlast,data}). Full/empty use the AW+1 pointer MSB compare.
//   Rewind and commit are single-cycle.
//  Read side: FWFT output register. out_tvalid=1 while the register holds a word. Refill when it is
//   empty, or when out_tvalid&&out_tready, provided rd_ptr!=commit_ptr.
//   Back-to-back transfer at 1 word/cycle.
//   Latency: footer accepted at cycle t -> header on out_tdata at t+2 (RAM read + out reg).
//  out_tdata/out_tlast hold stable while out_tvalid&&!out_tready.
//  Counters: err_* saturate at 255. pkt_good_count wraps at 65535.
//  Simultaneous commit and read on the same cycle: the read uses the pre-commit pointer,
//   so the new packet is visible the next cycle.
// STRUCTURE
//  sensor_packet_defs.vh: HEADER_VALUE, FOOTER_VALUE, N_RAW=512, N_PROC=3, FSM state codes.
//  Sub-module sensor_packet_fifo: dual-port RAM; wr_ptr/commit_ptr/rd_ptr; commit/rewind strobes;
//   FWFT out reg.
//  The checker top holds the FSM, overflow tracking and counters.
// TESTING
//  T1 processed pkt: AAAAAAAA,0x10,1,2,3,55555555 (tlast=1) -> 6 words out in order,
//     tlast on 55555555, good=1.
//  T2 raw pkt, raw_mode=1, 515 words, payload 1,3..1023 -> 515 words out, good=1,
//     no false footer match.
//  T3 footer word replaced by 0x12345678 -> nothing output, err_footer=1; next good pkt passes intact.
//  T4 out_tready=0, stream 2 raw pkts -> pkt1 committed, pkt2 dropped, err_overflow=1;
//     release ready -> exactly 515 words out.
//  T5 3 junk words, then pkt whose footer slot holds AAAAAAAA followed by a full pkt ->
//     err_sync=3, err_footer=1, 1 good pkt out.
//  T6 reset asserted mid-payload -> counters 0, out_tvalid=0; next pkt accepted normally.

Source files
------------

// File: rtl/sensor_packet_checker_pkg.sv
// Shared constants, types and helpers for the sensor packet checker.
package sensor_packet_checker_pkg;

  localparam int FIFO_DEPTH = 1024;
  localparam int AW         = 10;

  localparam logic [31:0] HEADER_VALUE = 32'hAAAA_AAAA;
  localparam logic [31:0] FOOTER_VALUE = 32'h5555_5555;
  localparam int          N_RAW        = 512;
  localparam int          N_PROC       = 3;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_TSTAMP  = 4'd1;
  localparam logic [3:0] ST_PAYLOAD = 4'd2;
  localparam logic [3:0] ST_FOOTER  = 4'd3;

  // Pointers carry one extra wrap bit above the RAM address.
  typedef logic [AW:0] ptr_t;

  // One buffer entry: the tlast flag travels with its word.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  // Full when the addresses match but the wrap bits differ.
  function automatic logic ptr_full(input ptr_t w, input ptr_t r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

endpackage

// File: rtl/sensor_packet_checker_if.sv
// Stream bundle between packetiser, checker and DMA.
// Handshake: a word moves on a rising clock edge when its tvalid and tready are both 1;
// while tvalid is 1 and tready is 0 the producer holds tdata/tlast stable.
// The input side has in_tready tied high: the source never waits.
interface sensor_packet_checker_if;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready;

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/sensor_packet_checker_fifo.sv
// Commit/rewind packet buffer: writes become readable only after commit,
// a rewind discards everything written since the packet start.
// Read side is a synchronous RAM read stage followed by an FWFT output register.
module sensor_packet_checker_fifo
  import sensor_packet_checker_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  entry_t wr_entry,
  input  logic   rewind,
  input  ptr_t   rewind_ptr,
  input  logic   commit,
  output ptr_t   wr_ptr,
  output ptr_t   rd_ptr,
  output entry_t out_entry,
  output logic   out_valid,
  input  logic   out_ready
);

  entry_t mem [FIFO_DEPTH];
  ptr_t   commit_ptr;
  ptr_t   base;
  entry_t ram_q;
  logic   ram_valid;
  logic   out_load;
  logic   rd_issue;

  // A rewind and a fresh write can share a cycle: the write lands at the rewind point.
  assign base     = rewind ? rewind_ptr : wr_ptr;
  assign out_load = !out_valid || out_ready;
  assign rd_issue = (!ram_valid || out_load) && (rd_ptr != commit_ptr);

  // Buffer storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[base[AW-1:0]] <= wr_entry;
  end

  // Write and commit pointers; commit marks the word being written as the new end.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      wr_ptr <= base + {{AW{1'b0}}, wr_en};
      if (commit) commit_ptr <= base + ptr_t'(1);
    end
  end

  // RAM read stage, held while the output register is stalled.
  always_ff @(posedge clk) begin
    if (rd_issue) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // Read pointer, read-stage valid and the FWFT output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      out_valid <= 1'b0;
      out_entry <= '0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + ptr_t'(1);
      if (rd_issue)      ram_valid <= 1'b1;
      else if (out_load) ram_valid <= 1'b0;
      if (out_load) begin
        out_valid <= ram_valid;
        if (ram_valid) out_entry <= ram_q;
      end
    end
  end

endmodule

// File: rtl/sensor_packet_checker.sv
// Frames header/timestamp/payload/footer packets, forwards good packets through
// the commit/rewind buffer and drops malformed or overflowing packets whole.
module sensor_packet_checker
  import sensor_packet_checker_pkg::*;
(
  input  logic                   master_clock,
  input  logic                   reset,
  input  logic                   raw_mode,
  sensor_packet_checker_if.slave bus,
  output logic [15:0]            pkt_good_count,
  output logic [7:0]             err_sync,
  output logic [7:0]             err_footer,
  output logic [7:0]             err_overflow,
  output logic [3:0]             dbg_state
);

  logic [3:0] state, state_n;
  logic [9:0] cnt, n_m1;
  logic       ovf, ovf_n;
  ptr_t       pkt_start, wr_ptr, rd_ptr;
  logic       wr_en, wr_last, rewind, commit, new_pkt;
  logic       inc_good, inc_sync, inc_footer, inc_ovf;
  logic       is_hdr, is_ftr, full_cur, full_rst;
  entry_t     out_entry;
  logic       out_valid;

  assign bus.in_tready  = 1'b1;
  assign bus.out_tdata  = out_entry.data;
  assign bus.out_tlast  = out_entry.last;
  assign bus.out_tvalid = out_valid;
  assign dbg_state      = state;

  assign is_hdr   = (bus.in_tdata == HEADER_VALUE);
  assign is_ftr   = (bus.in_tdata == FOOTER_VALUE);
  // full_rst is the space check for a header written back at the packet start.
  assign full_cur = ptr_full(wr_ptr, rd_ptr);
  assign full_rst = ptr_full(pkt_start, rd_ptr);

  // Parser decisions: buffer writes, commit/rewind and counter events.
  always_comb begin
    state_n    = state;
    ovf_n      = ovf;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    rewind     = 1'b0;
    commit     = 1'b0;
    new_pkt    = 1'b0;
    inc_good   = 1'b0;
    inc_sync   = 1'b0;
    inc_footer = 1'b0;
    inc_ovf    = 1'b0;
    if (bus.in_tvalid) begin
      case (state)
        ST_IDLE: begin
          if (is_hdr) begin
            new_pkt = 1'b1;
            wr_en   = !full_cur;
            ovf_n   = full_cur;
            state_n = ST_TSTAMP;
          end else begin
            inc_sync = 1'b1;
          end
        end
        ST_TSTAMP, ST_PAYLOAD: begin
          // Once a word has been lost the rest of the packet is not written.
          wr_en = !ovf && !full_cur;
          ovf_n = ovf || full_cur;
          if (state == ST_TSTAMP)  state_n = ST_PAYLOAD;
          else if (cnt == n_m1)    state_n = ST_FOOTER;
        end
        ST_FOOTER: begin
          ovf_n   = 1'b0;
          state_n = ST_IDLE;
          if (is_ftr) begin
            if (ovf || full_cur) begin
              rewind  = 1'b1;
              inc_ovf = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_last  = bus.in_tlast;
              commit   = 1'b1;
              inc_good = 1'b1;
            end
          end else begin
            rewind     = 1'b1;
            inc_footer = 1'b1;
            if (is_hdr) begin
              new_pkt = 1'b1;
              wr_en   = !full_rst;
              ovf_n   = full_rst;
              state_n = ST_TSTAMP;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Parser state, payload counter, packet start and overflow flag.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      n_m1      <= '0;
      ovf       <= 1'b0;
      pkt_start <= '0;
    end else begin
      state <= state_n;
      ovf   <= ovf_n;
      if (new_pkt && state == ST_IDLE) pkt_start <= wr_ptr;
      if (new_pkt) n_m1 <= raw_mode ? 10'(N_RAW - 1) : 10'(N_PROC - 1);
      if (bus.in_tvalid && state == ST_TSTAMP)       cnt <= '0;
      else if (bus.in_tvalid && state == ST_PAYLOAD) cnt <= cnt + 10'd1;
    end
  end

  // Good-packet count wraps; error counters stick at 255.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      pkt_good_count <= '0;
      err_sync       <= '0;
      err_footer     <= '0;
      err_overflow   <= '0;
    end else begin
      if (inc_good) pkt_good_count <= pkt_good_count + 16'd1;
      if (inc_sync && err_sync != 8'hFF)         err_sync     <= err_sync + 8'd1;
      if (inc_footer && err_footer != 8'hFF)     err_footer   <= err_footer + 8'd1;
      if (inc_ovf && err_overflow != 8'hFF)      err_overflow <= err_overflow + 8'd1;
    end
  end

  sensor_packet_checker_fifo u_fifo (
    .clk        (master_clock),
    .rst        (reset),
    .wr_en      (wr_en),
    .wr_entry   ({wr_last, bus.in_tdata}),
    .rewind     (rewind),
    .rewind_ptr (pkt_start),
    .commit     (commit),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .out_entry  (out_entry),
    .out_valid  (out_valid),
    .out_ready  (bus.out_tready)
  );

endmodule
